mem_block_copier: RTL and testbench
===================================

Name: mem_block_copier

Overview:
- Initiator that moves a block of words from one RAM region to another, driving one port of the multiport RAM.
- Acts as a DMA-style master beside the processor core.
- On a start command it alternates read and write accesses on its port until the programmed word count is copied, then pulses done.

Parameters:
- mem_width, 12, data word width; must match the RAM.
- addr_width, 12, address width; must match the RAM.
- len_width, 13, width of length field (addr_width+1), so a full 4096-word copy is expressible.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle command strobe; sampled only in IDLE
- src_addr  input  addr_width  first source word address
- dst_addr  input  addr_width  first destination word address
- length  input  len_width  number of words to copy
- mem_address  output  addr_width  RAM port address
- mem_datain  output  mem_width  RAM port write data
- mem_write  output  1  RAM port write enable
- mem_dataout  input  mem_width  RAM port read data, registered by the RAM at the clock edge
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse
- words_copied  output  len_width  count of words written in the current or last operation

Behaviour:
- Reset and clock: reset is synchronous, active-high; clock is clk.
- Reset values: state IDLE; mem_address 0; mem_datain 0; mem_write 0; busy 0; done 0; words_copied 0.
- RAM contract: address presented in cycle t yields data on mem_dataout in cycle t+1. A write and a read to the same address in one cycle return the new data.
- FSM states: IDLE, RD, WR, FIN.
- IDLE:
  - On start=1, latch src, dst and length into internal registers, clear words_copied, and go to RD.
  - If the latched length is 0, go to FIN instead.
  - In this state mem_write=0.
- RD:
  - Drive mem_address = src_ptr, mem_write=0.
  - Next state is WR.
- WR:
  - Drive mem_address = dst_ptr, mem_datain = mem_dataout (combinational pass-through), mem_write=1.
  - At the clock edge: src_ptr+1, dst_ptr+1, words_copied+1, remaining-1.
  - If remaining was 1, go to FIN; otherwise go to RD.
- FIN: done=1 for exactly this cycle, busy=0, mem_write=0; then IDLE.
- Throughput: 2 cycles per word. Total latency from the start edge to the done cycle is 2*length+1 cycles (length≥1); for length 0, done comes in the cycle after start.
- Pointer arithmetic: pointers wrap modulo 2^addr_width (4095+1 → 0). Length is never truncated.
- Overlap: copy is strictly forward, ascending. If dst is inside (src, src+length), the copy propagates already-overwritten data; this is the defined behaviour and is not detected.
- start while busy or in FIN: ignored; no queuing.
- Inputs are sampled only on the accepted start cycle. Later changes to src_addr, dst_addr or length have no effect.
- Reset mid-operation: aborts at once; mem_write falls to 0 in the next cycle and no done pulse is produced. Partially copied words stay in RAM.
- words_copied: holds its final value after done until the next accepted start.
- mem_address and mem_datain are don't-care when mem_write=0 outside RD. Both are driven to 0 in IDLE and FIN.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, RD=1, WR=2, FIN=3);
  - default widths MEM_WIDTH=12, ADDR_WIDTH=12;
  - MEM_SIZE=4096.
- One sub-module is natural: mem_copy_counter, a loadable down-counter with a zero flag and a paired up-counter for words_copied.
- Pointers and the FSM stay in the top module.

Test Plan:
- Basic copy:
  - Stimulus: RAM[0x010..0x013]=0xA01,0xA02,0xA03,0xA04; start with src=0x010, dst=0x100, length=4.
  - Response: RAM[0x100..0x103] equal the source; done is asserted 9 cycles after start; words_copied=4; exactly 4 mem_write pulses.
- Zero length:
  - Stimulus: start with length=0.
  - Response: done in the next cycle, no mem_write, words_copied=0.
- Wrap-around:
  - Stimulus: src=0xFFE, dst=0x7FF, length=3, RAM[0xFFE]=0x111, RAM[0xFFF]=0x222, RAM[0x000]=0x333.
  - Response: RAM[0x7FF..0x801]=0x111,0x222,0x333.
- Start while busy:
  - Stimulus: second start with different arguments in cycle 3 of a length-4 copy.
  - Response: the second start is ignored; only the original destination is written; one done pulse.
- Reset mid-copy:
  - Stimulus: assert reset after the 2nd write of a length-8 copy.
  - Response: mem_write=0 from the next cycle; busy=0, done never asserted; only 2 destination words changed.
- Overlapping forward copy:
  - Stimulus: src=0x020, dst=0x021, length=3, RAM[0x020]=0x5A5.
  - Response: RAM[0x021..0x023] all 0x5A5.

Source files
------------

// File: rtl/mem_block_copier_pkg.sv
// Shared definitions for the block copier slice.
// Holds the default RAM geometry and the FSM state encoding used by
// mem_block_copier. Imported by the top module.
package mem_block_copier_pkg;

    localparam int MEM_WIDTH  = 12;
    localparam int ADDR_WIDTH = 12;
    localparam int MEM_SIZE   = 4096;

    // Copier FSM encoding, kept as plain constants so older tools and
    // waveform scripts that decode the raw state value keep working.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

endpackage

// File: rtl/mem_copy_counter.sv
// Word counters for the block copier.
// A loadable down-counter tracks how many words are still to be copied,
// and a paired up-counter reports how many words have been written.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   load         - take load_value into remaining and clear count
//   load_value   - programmed word count
//   step         - one word written: remaining-1, count+1
//   remaining    - words still to copy
//   last         - remaining equals one (the current word is the final one)
//   zero         - remaining equals zero
//   count        - words written since the last load; holds after completion
module mem_copy_counter #(
    parameter int len_width = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [len_width-1:0] load_value,
    input  logic                 step,
    output logic [len_width-1:0] remaining,
    output logic                 last,
    output logic                 zero,
    output logic [len_width-1:0] count
);

    localparam logic [len_width-1:0] ONE = len_width'(1);

    // Load has priority over step; the FSM never asks for both at once,
    // but a fresh command must always start from a clean count.
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining <= '0;
            count     <= '0;
        end else if (load) begin
            remaining <= load_value;
            count     <= '0;
        end else if (step) begin
            remaining <= remaining - ONE;
            count     <= count + ONE;
        end
    end

    assign last = (remaining == ONE);
    assign zero = (remaining == '0);

endmodule

// File: rtl/mem_block_copier.sv
// DMA-style block copier driving one port of the multiport RAM.
// On an accepted start it alternates a read cycle (source address) and a
// write cycle (destination address, data passed straight through from the
// RAM read port) until the programmed number of words is copied, then
// pulses done for one cycle. Copying is strictly ascending; pointers wrap
// modulo the RAM size.
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   start         - command strobe, only honoured when idle
//   src_addr      - first source word address
//   dst_addr      - first destination word address
//   length        - number of words to copy (0 .. 2^addr_width)
//   mem_address   - RAM port address
//   mem_datain    - RAM port write data
//   mem_write     - RAM port write enable
//   mem_dataout   - RAM port read data, one cycle after the address
//   busy          - copy in progress (read/write phases)
//   done          - one-cycle completion pulse
//   words_copied  - words written by the current or last operation
module mem_block_copier
    import mem_block_copier_pkg::*;
#(
    parameter int mem_width  = MEM_WIDTH,
    parameter int addr_width = ADDR_WIDTH,
    parameter int len_width  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addr_width-1:0] src_addr,
    input  logic [addr_width-1:0] dst_addr,
    input  logic [len_width-1:0]  length,
    output logic [addr_width-1:0] mem_address,
    output logic [mem_width-1:0]  mem_datain,
    output logic                  mem_write,
    input  logic [mem_width-1:0]  mem_dataout,
    output logic                  busy,
    output logic                  done,
    output logic [len_width-1:0]  words_copied
);

    localparam logic [addr_width-1:0] ADDR_ONE = addr_width'(1);

    logic [1:0]            state;
    logic [addr_width-1:0] src_ptr;
    logic [addr_width-1:0] dst_ptr;
    logic [len_width-1:0]  remaining;
    logic                  last;
    logic                  zero;
    logic                  accept;
    logic                  step;

    assign accept = (state == ST_IDLE) && start;
    assign step   = (state == ST_WR);

    mem_copy_counter #(
        .len_width (len_width)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (length),
        .step       (step),
        .remaining  (remaining),
        .last       (last),
        .zero       (zero),
        .count      (words_copied)
    );

    // Sequencer and address pointers. Pointers are only captured on an
    // accepted start, so later changes on the command inputs are ignored.
    // The zero check in WR is defensive: a zero-length command never
    // reaches RD/WR, but it guarantees the loop cannot run away.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        src_ptr <= src_addr;
                        dst_ptr <= dst_addr;
                        state   <= (length == '0) ? ST_FIN : ST_RD;
                    end
                end
                ST_RD: begin
                    state <= ST_WR;
                end
                ST_WR: begin
                    src_ptr <= src_ptr + ADDR_ONE;
                    dst_ptr <= dst_ptr + ADDR_ONE;
                    state   <= (last || zero) ? ST_FIN : ST_RD;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM port drive. In WR the data read during the preceding RD cycle is
    // on mem_dataout and is forwarded combinationally as write data.
    always_comb begin
        mem_address = '0;
        mem_datain  = '0;
        mem_write   = 1'b0;
        case (state)
            ST_RD: begin
                mem_address = src_ptr;
            end
            ST_WR: begin
                mem_address = dst_ptr;
                mem_datain  = mem_dataout;
                mem_write   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy = (state == ST_RD) || (state == ST_WR);
    assign done = (state == ST_FIN);

endmodule

// File: tb/tb_mem_block_copier.sv
// Self-checking bench for mem_block_copier.
// A behavioural RAM with a backdoor preload port sits on the copier's port.
// Expected writes are computed on a shadow copy of RAM when a copy is
// launched and queued; every observed mem_write pops and checks one entry.
module tb_mem_block_copier;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] src_addr;
    logic [11:0] dst_addr;
    logic [12:0] length;
    logic [11:0] mem_address;
    logic [11:0] mem_datain;
    logic        mem_write;
    logic [11:0] mem_dataout;
    logic        busy;
    logic        done;
    logic [12:0] words_copied;

    logic        bd_we;
    logic [11:0] bd_addr;
    logic [11:0] bd_data;

    logic [11:0] ram    [0:4095];
    logic [11:0] shadow [0:4095];

    typedef struct packed {
        logic [11:0] addr;
        logic [11:0] data;
    } wr_t;

    wr_t exp_q[$];

    int compared    = 0;
    int mismatched  = 0;
    int writes_seen = 0;
    int done_count  = 0;

    mem_block_copier dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .length       (length),
        .mem_address  (mem_address),
        .mem_datain   (mem_datain),
        .mem_write    (mem_write),
        .mem_dataout  (mem_dataout),
        .busy         (busy),
        .done         (done),
        .words_copied (words_copied)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: registered read, write-first on the single port.
    always @(posedge clk) begin
        if (bd_we)
            ram[bd_addr] <= bd_data;
        else if (mem_write)
            ram[mem_address] <= mem_datain;
        mem_dataout <= mem_write ? mem_datain : ram[mem_address];
    end

    // Scoreboard on the write port plus done pulse counter.
    always @(negedge clk) begin
        wr_t e;
        if (done)
            done_count++;
        if (mem_write) begin
            writes_seen++;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL write_unexpected: got addr=%h data=%h, expected no write",
                         mem_address, mem_datain);
            end else begin
                e = exp_q.pop_front();
                if ({mem_address, mem_datain} !== {e.addr, e.data}) begin
                    mismatched++;
                    $display("[TB] FAIL write_check: got addr=%h data=%h, expected addr=%h data=%h",
                             mem_address, mem_datain, e.addr, e.data);
                end
            end
        end
    end

    task automatic poke(input logic [11:0] a, input logic [11:0] d);
        @(posedge clk);
        #1;
        shadow[a] = d;
        bd_we     = 1'b1;
        bd_addr   = a;
        bd_data   = d;
        @(posedge clk);
        #1;
        bd_we     = 1'b0;
    endtask

    // Queue the expected writes, launch a copy, and measure cycles from the
    // accepting edge to the done cycle (-1 on timeout). Optionally fires a
    // second start with different arguments at cycle 'inject'.
    task automatic run_copy(input logic [11:0] s, input logic [11:0] d,
                            input logic [12:0] n, input int inject,
                            output int lat);
        logic [11:0] sa;
        logic [11:0] da;
        for (int i = 0; i < int'(n); i++) begin
            sa = s + 12'(i);
            da = d + 12'(i);
            shadow[da] = shadow[sa];
            exp_q.push_back(wr_t'{addr: da, data: shadow[da]});
        end
        @(posedge clk);
        #1;
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        length   = n;
        @(posedge clk);
        #1;
        start    = 1'b0;
        src_addr = 12'hABC;
        dst_addr = 12'hDEF;
        length   = 13'd77;
        lat = -1;
        for (int k = 1; k <= 2 * int'(n) + 20; k++) begin
            @(negedge clk);
            if (inject != 0 && k == inject) begin
                start    = 1'b1;
                src_addr = 12'h555;
                dst_addr = 12'h600;
                length   = 13'd2;
            end
            if (inject != 0 && k == inject + 1)
                start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared += 6;
        if (mem_address !== 12'h000) begin mismatched++; $display("[TB] FAIL reset_mem_address: got %h expected 000", mem_address); end
        if (mem_datain !== 12'h000) begin mismatched++; $display("[TB] FAIL reset_mem_datain: got %h expected 000", mem_datain); end
        if (mem_write !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_write: got %b expected 0", mem_write); end
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        if (words_copied !== 13'd0) begin mismatched++; $display("[TB] FAIL reset_words_copied: got %0d expected 0", words_copied); end
        reset = 1'b0;
    endtask

    task automatic test_basic_copy();
        int lat, w0, d0;
        for (int i = 0; i < 4; i++)
            poke(12'h010 + 12'(i), 12'hA01 + 12'(i));
        w0 = writes_seen;
        d0 = done_count;
        run_copy(12'h010, 12'h100, 13'd4, 0, lat);
        @(posedge clk);
        #1;
        compared += 5;
        if (lat !== 9) begin mismatched++; $display("[TB] FAIL basic_latency: got %0d expected 9", lat); end
        if (words_copied !== 13'd4) begin mismatched++; $display("[TB] FAIL basic_words_copied: got %0d expected 4", words_copied); end
        if (writes_seen - w0 !== 4) begin mismatched++; $display("[TB] FAIL basic_write_count: got %0d expected 4", writes_seen - w0); end
        if (done_count - d0 !== 1) begin mismatched++; $display("[TB] FAIL basic_done_count: got %0d expected 1", done_count - d0); end
        if (exp_q.size() !== 0) begin mismatched++; $display("[TB] FAIL basic_pending: got %0d expected 0", exp_q.size()); end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (ram[12'h100 + 12'(i)] !== 12'hA01 + 12'(i)) begin
                mismatched++;
                $display("[TB] FAIL basic_ram[%0d]: got %h expected %h", i, ram[12'h100 + 12'(i)], 12'hA01 + 12'(i));
            end
        end
    endtask

    task automatic test_zero_length();
        int lat, w0;
        compared++;
        if (words_copied !== 13'd4) begin mismatched++; $display("[TB] FAIL zero_hold_count: got %0d expected 4", words_copied); end
        w0 = writes_seen;
        run_copy(12'h050, 12'h060, 13'd0, 0, lat);
        @(posedge clk);
        #1;
        compared += 3;
        if (lat !== 1) begin mismatched++; $display("[TB] FAIL zero_latency: got %0d expected 1", lat); end
        if (writes_seen - w0 !== 0) begin mismatched++; $display("[TB] FAIL zero_write_count: got %0d expected 0", writes_seen - w0); end
        if (words_copied !== 13'd0) begin mismatched++; $display("[TB] FAIL zero_words_copied: got %0d expected 0", words_copied); end
    endtask

    task automatic test_wrap_around();
        int lat;
        logic [11:0] want [0:2];
        want[0] = 12'h111;
        want[1] = 12'h222;
        want[2] = 12'h333;
        poke(12'hFFE, 12'h111);
        poke(12'hFFF, 12'h222);
        poke(12'h000, 12'h333);
        run_copy(12'hFFE, 12'h7FF, 13'd3, 0, lat);
        @(posedge clk);
        #1;
        compared++;
        if (lat !== 7) begin mismatched++; $display("[TB] FAIL wrap_latency: got %0d expected 7", lat); end
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (ram[12'h7FF + 12'(i)] !== want[i]) begin
                mismatched++;
                $display("[TB] FAIL wrap_ram[%0d]: got %h expected %h", i, ram[12'h7FF + 12'(i)], want[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int lat, d0;
        for (int i = 0; i < 4; i++)
            poke(12'h040 + 12'(i), 12'hB01 + 12'(i));
        poke(12'h600, 12'hEEE);
        poke(12'h601, 12'hEEE);
        d0 = done_count;
        run_copy(12'h040, 12'h140, 13'd4, 3, lat);
        repeat (6) @(posedge clk);
        #1;
        compared += 4;
        if (lat !== 9) begin mismatched++; $display("[TB] FAIL busy_latency: got %0d expected 9", lat); end
        if (done_count - d0 !== 1) begin mismatched++; $display("[TB] FAIL busy_done_count: got %0d expected 1", done_count - d0); end
        if (ram[12'h600] !== 12'hEEE) begin mismatched++; $display("[TB] FAIL busy_alt_dst: got %h expected eee", ram[12'h600]); end
        if (words_copied !== 13'd4) begin mismatched++; $display("[TB] FAIL busy_words_copied: got %0d expected 4", words_copied); end
    endtask

    task automatic test_reset_mid_copy();
        int d0, w0;
        bit reached;
        for (int i = 0; i < 8; i++) begin
            poke(12'h200 + 12'(i), 12'hC00 + 12'(i));
            poke(12'h300 + 12'(i), 12'hDDD);
        end
        for (int i = 0; i < 8; i++)
            exp_q.push_back(wr_t'{addr: 12'h300 + 12'(i), data: shadow[12'h200 + 12'(i)]});
        d0 = done_count;
        w0 = writes_seen;
        @(posedge clk);
        #1;
        start    = 1'b1;
        src_addr = 12'h200;
        dst_addr = 12'h300;
        length   = 13'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (writes_seen - w0 == 2) begin
                reached = 1'b1;
                break;
            end
        end
        compared++;
        if (!reached) begin mismatched++; $display("[TB] FAIL rst_second_write: got %0d writes expected 2", writes_seen - w0); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        shadow[12'h300] = 12'hC00;
        shadow[12'h301] = 12'hC01;
        compared += 3;
        if (mem_write !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mem_write: got %b expected 0", mem_write); end
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        if (words_copied !== 13'd0) begin mismatched++; $display("[TB] FAIL rst_words_copied: got %0d expected 0", words_copied); end
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        compared += 5;
        if (done_count - d0 !== 0) begin mismatched++; $display("[TB] FAIL rst_done_count: got %0d expected 0", done_count - d0); end
        if (ram[12'h300] !== 12'hC00) begin mismatched++; $display("[TB] FAIL rst_ram0: got %h expected c00", ram[12'h300]); end
        if (ram[12'h301] !== 12'hC01) begin mismatched++; $display("[TB] FAIL rst_ram1: got %h expected c01", ram[12'h301]); end
        if (ram[12'h302] !== 12'hDDD) begin mismatched++; $display("[TB] FAIL rst_ram2: got %h expected ddd", ram[12'h302]); end
        if (ram[12'h307] !== 12'hDDD) begin mismatched++; $display("[TB] FAIL rst_ram7: got %h expected ddd", ram[12'h307]); end
    endtask

    task automatic test_overlap();
        int lat;
        poke(12'h020, 12'h5A5);
        poke(12'h021, 12'h000);
        poke(12'h022, 12'h000);
        poke(12'h023, 12'h000);
        run_copy(12'h020, 12'h021, 13'd3, 0, lat);
        @(posedge clk);
        #1;
        compared++;
        if (lat !== 7) begin mismatched++; $display("[TB] FAIL overlap_latency: got %0d expected 7", lat); end
        for (int i = 1; i <= 3; i++) begin
            compared++;
            if (ram[12'h020 + 12'(i)] !== 12'h5A5) begin
                mismatched++;
                $display("[TB] FAIL overlap_ram[%0d]: got %h expected 5a5", i, ram[12'h020 + 12'(i)]);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        src_addr = 12'h000;
        dst_addr = 12'h000;
        length   = 13'd0;
        bd_we    = 1'b0;
        bd_addr  = 12'h000;
        bd_data  = 12'h000;
        $display("[TB] mem_block_copier bench starting");
        test_reset();
        test_basic_copy();
        test_zero_length();
        test_wrap_around();
        test_start_while_busy();
        test_reset_mid_copy();
        test_overlap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
